// File: rtl/mips_cpu_bus_pkg.sv
// Shared types and helpers for the MIPS CPU load/store unit.
// Opcodes, FSM states and access-size decoding.
package mips_cpu_bus_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic is_store(lsu_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic [1:0] op_size(lsu_op_t op);
    case (op)
      LB, LBU, SB: return SZ_BYTE;
      LH, LHU, SH: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_bus_lsu_if.sv
// CPU data bus: read/write strobes, byte enables and waitrequest stall.
// The LSU is the master; the memory model is the slave.
interface mips_cpu_bus_lsu_if #(
  parameter int ADDR_W = 24
);
  logic [ADDR_W-1:0] addr;
  logic              read;
  logic              write;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic              waitrequest;
  logic [31:0]       readdata;

  modport master (
    output addr, read, write, byteenable, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  addr, read, write, byteenable, writedata,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_cpu_bus_lsu_align.sv
// Lane selection, misalignment detection, store replication and load extension.
// Readdata arrives with the enabled lanes already packed toward bit 0.
module mips_cpu_bus_lsu_align
  import mips_cpu_bus_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic        misaligned,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  always_comb begin
    be         = 4'b1111;
    misaligned = 1'b0;
    case (op_size(op))
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: begin
        be         = lane[1] ? 4'b1100 : 4'b0011;
        misaligned = lane[0];
      end
      default: misaligned = |lane;
    endcase
  end

  always_comb begin
    wdata_lane = wdata;
    case (op)
      SB:      wdata_lane = {4{wdata[7:0]}};
      SH:      wdata_lane = {2{wdata[15:0]}};
      default: wdata_lane = wdata;
    endcase
  end

  always_comb begin
    rdata_ext = 32'd0;
    case (op)
      LB:      rdata_ext = {{24{rdata[7]}}, rdata[7:0]};
      LBU:     rdata_ext = {24'd0, rdata[7:0]};
      LH:      rdata_ext = {{16{rdata[15]}}, rdata[15:0]};
      LHU:     rdata_ext = {16'd0, rdata[15:0]};
      LW:      rdata_ext = rdata;
      default: rdata_ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_lsu.sv
// Load/store unit bus master: one request at a time, single bus transaction,
// aligned and extended result returned as a one-cycle pulse.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// BUS   | read/write strobe held until waitrequest drops
// RESP  | rsp_valid pulse (load data, or misalignment fault)
module mips_cpu_bus_lsu
  import mips_cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  lsu_op_t             req_op,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [4:0]          req_rd,
  output logic                rsp_valid,
  output logic [31:0]         rsp_data,
  output logic [4:0]          rsp_rd,
  output logic                rsp_misaligned,
  mips_cpu_bus_lsu_if.master  bus
);

  lsu_state_t        state_q, state_d;
  lsu_op_t           op_q, op_sel;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, result_q;
  logic [4:0]        rd_q;
  logic              mis_q;
  logic [1:0]        lane_sel;
  logic [31:0]       wdata_sel;
  logic [3:0]        be;
  logic              misaligned;
  logic [31:0]       wdata_lane, rdata_ext;
  logic              accept;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^req_addr;

  // While idle the aligner looks at the incoming request to flag faults at accept.
  assign op_sel    = (state_q == IDLE) ? req_op : op_q;
  assign lane_sel  = (state_q == IDLE) ? req_addr[1:0] : addr_q[1:0];
  assign wdata_sel = (state_q == IDLE) ? req_wdata : wdata_q;
  assign accept    = req_valid && (state_q == IDLE);

  mips_cpu_bus_lsu_align u_align (
    .op         (op_sel),
    .lane       (lane_sel),
    .wdata      (wdata_sel),
    .rdata      (bus.readdata),
    .be         (be),
    .misaligned (misaligned),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= LB;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rd_q     <= 5'd0;
      mis_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= req_op;
        addr_q   <= req_addr[ADDR_W-1:0];
        wdata_q  <= req_wdata;
        rd_q     <= req_rd;
        mis_q    <= misaligned;
        result_q <= 32'd0;
      end else if (state_q == BUS && !bus.waitrequest) begin
        result_q <= rdata_ext;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = misaligned ? RESP : BUS;
      BUS:     if (!bus.waitrequest) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (state_q == IDLE);
    rsp_valid      = 1'b0;
    rsp_data       = 32'd0;
    rsp_rd         = 5'd0;
    rsp_misaligned = 1'b0;
    bus.addr       = '0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.byteenable = 4'b0000;
    bus.writedata  = 32'd0;
    if (state_q == BUS) begin
      bus.addr       = {addr_q[ADDR_W-1:2], 2'b00};
      bus.read       = !is_store(op_q);
      bus.write      = is_store(op_q);
      bus.byteenable = be;
      bus.writedata  = is_store(op_q) ? wdata_lane : 32'd0;
    end
    if (state_q == RESP) begin
      rsp_valid      = 1'b1;
      rsp_data       = result_q;
      rsp_rd         = rd_q;
      rsp_misaligned = mis_q;
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_lsu.sv
// Directed bench for mips_cpu_bus_lsu with a byte-lane memory model and
// injectable waitrequest stalls.
module tb_mips_cpu_bus_lsu;
  import mips_cpu_bus_pkg::*;

  localparam int ADDR_W = 24;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  lsu_op_t     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_misaligned;

  int checks = 0;
  int errors = 0;

  int stall_req = 0;
  int stall_seen = 0;
  logic [7:0] mem [0:255];

  mips_cpu_bus_lsu_if #(.ADDR_W(ADDR_W)) bus ();

  mips_cpu_bus_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_rd         (req_rd),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_rd         (rsp_rd),
    .rsp_misaligned (rsp_misaligned),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: enabled lanes packed toward bit 0 on reads, lane-placed writes.
  assign bus.waitrequest = (bus.read || bus.write) && (stall_seen < stall_req);

  always_comb begin
    int k;
    bus.readdata = 32'd0;
    k = 0;
    if (bus.read) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byteenable[i]) begin
          bus.readdata[k*8 +: 8] = mem[{bus.addr[7:2], 2'(i)}];
          k++;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (bus.write && !bus.waitrequest) begin
      for (int i = 0; i < 4; i++)
        if (bus.byteenable[i]) mem[{bus.addr[7:2], 2'(i)}] <= bus.writedata[i*8 +: 8];
    end
    if (bus.read || bus.write) begin
      if (bus.waitrequest) stall_seen <= stall_seen + 1;
    end else begin
      stall_seen <= 0;
    end
  end

  // Issues one request and reports cycle-1 bus values plus the response (lat = -1 on timeout).
  task automatic run_req(input lsu_op_t op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, output int lat, output logic [31:0] data,
                         output logic mis, output logic [4:0] tag, output logic rd1,
                         output logic wr1, output logic [3:0] be1, output logic [31:0] wd1,
                         output logic [ADDR_W-1:0] a1);
    @(negedge clk);
    req_op = op; req_addr = a; req_wdata = wd; req_rd = rd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; data = 32'hx; mis = 1'bx; tag = 5'hx;
    rd1 = 1'b0; wr1 = 1'b0; be1 = 4'h0; wd1 = 32'h0; a1 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        rd1 = bus.read; wr1 = bus.write; be1 = bus.byteenable;
        wd1 = bus.writedata; a1 = bus.addr;
      end
      if (rsp_valid) begin
        lat = c; data = rsp_data; mis = rsp_misaligned; tag = rsp_rd;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || bus.read !== 1'b0 || bus.write !== 1'b0 ||
        bus.byteenable !== 4'h0 || bus.addr !== '0 || rsp_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rsp_valid=%b read=%b write=%b be=%b addr=%h data=%h, required ready=1 and all others 0",
               req_ready, rsp_valid, bus.read, bus.write, bus.byteenable, bus.addr, rsp_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_word_store();
    int lat; logic [31:0] d, wd1; logic mis, r1, w1; logic [4:0] tag; logic [3:0] be1;
    logic [ADDR_W-1:0] a1;
    run_req(SW, 32'h18, 32'habcd12ff, 5'd3, lat, d, mis, tag, r1, w1, be1, wd1, a1);
    checks++;
    if (w1 !== 1'b1 || r1 !== 1'b0 || a1 !== 24'h18 || be1 !== 4'b1111 || wd1 !== 32'habcd12ff) begin
      errors++;
      $display("FAIL sw_bus: write=%b read=%b addr=%h be=%b wd=%h, required 1 0 000018 1111 abcd12ff",
               w1, r1, a1, be1, wd1);
    end
    checks++;
    if (lat !== 2 || d !== 32'd0 || mis !== 1'b0 || tag !== 5'd3) begin
      errors++;
      $display("FAIL sw_rsp: lat=%0d data=%h mis=%b rd=%0d, required 2 00000000 0 3", lat, d, mis, tag);
    end
  endtask

  task automatic test_byte_loads();
    int lat; logic [31:0] d, wd1; logic mis, r1, w1; logic [4:0] tag; logic [3:0] be1;
    logic [ADDR_W-1:0] a1;
    run_req(LB, 32'h1b, 32'h0, 5'd7, lat, d, mis, tag, r1, w1, be1, wd1, a1);
    checks++;
    if (r1 !== 1'b1 || w1 !== 1'b0 || be1 !== 4'b1000 || a1 !== 24'h18) begin
      errors++;
      $display("FAIL lb_bus: read=%b write=%b be=%b addr=%h, required 1 0 1000 000018", r1, w1, be1, a1);
    end
    checks++;
    if (lat !== 2 || d !== 32'hffffffab || tag !== 5'd7) begin
      errors++;
      $display("FAIL lb_1b: lat=%0d data=%h rd=%0d, required 2 ffffffab 7", lat, d, tag);
    end
    run_req(LBU, 32'h1b, 32'h0, 5'd8, lat, d, mis, tag, r1, w1, be1, wd1, a1);
    checks++;
    if (d !== 32'h000000ab || lat !== 2) begin
      errors++;
      $display("FAIL lbu_1b: data=%h lat=%0d, required 000000ab 2", d, lat);
    end
    run_req(LB, 32'h18, 32'h0, 5'd9, lat, d, mis, tag, r1, w1, be1, wd1, a1);
    checks++;
    if (d !== 32'hffffffff || be1 !== 4'b0001) begin
      errors++;
      $display("FAIL lb_18: data=%h be=%b, required ffffffff 0001", d, be1);
    end
  endtask

  task automatic test_half_loads();
    int lat; logic [31:0] d, wd1; logic mis, r1, w1; logic [4:0] tag; logic [3:0] be1;
    logic [ADDR_W-1:0] a1;
    run_req(LH, 32'h1a, 32'h0, 5'd10, lat, d, mis, tag, r1, w1, be1, wd1, a1);
    checks++;
    if (be1 !== 4'b1100 || d !== 32'hffffabcd || mis !== 1'b0) begin
      errors++;
      $display("FAIL lh_1a: be=%b data=%h mis=%b, required 1100 ffffabcd 0", be1, d, mis);
    end
    run_req(LHU, 32'h18, 32'h0, 5'd11, lat, d, mis, tag, r1, w1, be1, wd1, a1);
    checks++;
    if (be1 !== 4'b0011 || d !== 32'h000012ff) begin
      errors++;
      $display("FAIL lhu_18: be=%b data=%h, required 0011 000012ff", be1, d);
    end
  endtask

  task automatic test_byte_store();
    int lat; logic [31:0] d, wd1; logic mis, r1, w1; logic [4:0] tag; logic [3:0] be1;
    logic [ADDR_W-1:0] a1;
    run_req(SB, 32'h19, 32'h0000005a, 5'd12, lat, d, mis, tag, r1, w1, be1, wd1, a1);
    checks++;
    if (w1 !== 1'b1 || be1 !== 4'b0010 || wd1 !== 32'h5a5a5a5a) begin
      errors++;
      $display("FAIL sb_19: write=%b be=%b wd=%h, required 1 0010 5a5a5a5a", w1, be1, wd1);
    end
    run_req(LW, 32'h18, 32'h0, 5'd13, lat, d, mis, tag, r1, w1, be1, wd1, a1);
    checks++;
    if (d !== 32'habcd5aff || be1 !== 4'b1111 || tag !== 5'd13) begin
      errors++;
      $display("FAIL lw_after_sb: data=%h be=%b rd=%0d, required abcd5aff 1111 13", d, be1, tag);
    end
  endtask

  task automatic test_half_store();
    int lat; logic [31:0] d, wd1; logic mis, r1, w1; logic [4:0] tag; logic [3:0] be1;
    logic [ADDR_W-1:0] a1;
    run_req(SH, 32'h1e, 32'hffff1234, 5'd14, lat, d, mis, tag, r1, w1, be1, wd1, a1);
    checks++;
    if (be1 !== 4'b1100 || wd1 !== 32'h12341234 || a1 !== 24'h1c) begin
      errors++;
      $display("FAIL sh_1e: be=%b wd=%h addr=%h, required 1100 12341234 00001c", be1, wd1, a1);
    end
    run_req(LW, 32'h1c, 32'h0, 5'd15, lat, d, mis, tag, r1, w1, be1, wd1, a1);
    checks++;
    if (d !== 32'h12340000) begin
      errors++;
      $display("FAIL lw_after_sh: data=%h, required 12340000", d);
    end
  endtask

  task automatic test_stall();
    int lat;
    logic ok;
    stall_req = 3;
    @(negedge clk);
    req_op = LW; req_addr = 32'h18; req_rd = 5'd16; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    ok = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c <= 4 && (bus.read !== 1'b1 || bus.addr !== 24'h18 || bus.byteenable !== 4'b1111 ||
                     req_ready !== 1'b0))
        ok = 1'b0;
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_stable: bus outputs changed during stall, required read=1 addr=000018 be=1111");
    end
    checks++;
    if (lat !== 5 || rsp_data !== 32'habcd5aff) begin
      errors++;
      $display("FAIL stall_latency: lat=%0d data=%h, required 5 abcd5aff", lat, rsp_data);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_ready: ready=%b rsp_valid=%b after pulse, required 1 0", req_ready, rsp_valid);
    end
    stall_req = 0;
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] d, wd1; logic mis, r1, w1; logic [4:0] tag; logic [3:0] be1;
    logic [ADDR_W-1:0] a1;
    run_req(LH, 32'h19, 32'h0, 5'd17, lat, d, mis, tag, r1, w1, be1, wd1, a1);
    checks++;
    if (lat !== 1 || mis !== 1'b1 || r1 !== 1'b0 || w1 !== 1'b0 || d !== 32'd0 || tag !== 5'd17) begin
      errors++;
      $display("FAIL lh_misaligned: lat=%0d mis=%b read=%b write=%b data=%h rd=%0d, required 1 1 0 0 00000000 17",
               lat, mis, r1, w1, d, tag);
    end
    run_req(SW, 32'h1a, 32'hdeadbeef, 5'd18, lat, d, mis, tag, r1, w1, be1, wd1, a1);
    checks++;
    if (lat !== 1 || mis !== 1'b1 || w1 !== 1'b0) begin
      errors++;
      $display("FAIL sw_misaligned: lat=%0d mis=%b write=%b, required 1 1 0", lat, mis, w1);
    end
    run_req(LW, 32'h18, 32'h0, 5'd19, lat, d, mis, tag, r1, w1, be1, wd1, a1);
    checks++;
    if (d !== 32'habcd5aff || mis !== 1'b0) begin
      errors++;
      $display("FAIL no_write_on_fault: data=%h mis=%b, required abcd5aff 0", d, mis);
    end
    run_req(LB, 32'h1d, 32'h0, 5'd20, lat, d, mis, tag, r1, w1, be1, wd1, a1);
    checks++;
    if (mis !== 1'b0 || be1 !== 4'b0010 || d !== 32'h00000000 || lat !== 2) begin
      errors++;
      $display("FAIL lb_odd_ok: mis=%b be=%b data=%h lat=%0d, required 0 0010 00000000 2", mis, be1, d, lat);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic seen;
    stall_req = 50;
    @(negedge clk);
    req_op = LW; req_addr = 32'h18; req_rd = 5'd21; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.read !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_read: read=%b, required 1", bus.read);
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.read !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stall: read=%b ready=%b rsp_valid=%b, required 0 1 0",
               bus.read, req_ready, rsp_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    stall_req = 0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || bus.read) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abandoned_txn: response or strobe seen after reset=%b, required 0", seen);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset_n = 1'b0; req_valid = 1'b0; req_op = LB;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    test_reset();
    test_word_store();
    test_byte_loads();
    test_half_loads();
    test_byte_store();
    test_half_store();
    test_stall();
    test_misaligned();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_cpu_bus_lsu.md
# mips_cpu_bus_lsu

Load/store unit bus master for the bus-interfaced MIPS CPU. It accepts one load or store request at a time from the execute stage and issues a single transaction on the CPU data bus, the same read/write/byteenable/waitrequest bus that serves `mips_cpu_bus_tb_memory`. It returns the aligned, sign- or zero-extended result to writeback. It sits between the CPU datapath and the memory bus and owns lane selection, store data replication and waitrequest stalling.

## Interface
- `ADDR_W`, default 24: bus address width; the low `ADDR_W` bits of `req_addr` are used.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle; a request is accepted on `req_valid && req_ready`.
- `req_op` in 3: `lsu_op_t` operation, one of LB, LBU, LH, LHU, LW, SB, SH, SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `req_rd` in 5: destination register tag, returned unchanged.
- `rsp_valid` out 1: one-cycle completion pulse; there is no backpressure.
- `rsp_data` out 32: load result; 0 for stores and for faults.
- `rsp_rd` out 5: tag of the completing request.
- `rsp_misaligned` out 1: alignment fault, valid with `rsp_valid`.
- `addr` out `ADDR_W`: word-aligned bus address (bits [1:0] = 0).
- `read` out 1: bus read strobe.
- `write` out 1: bus write strobe.
- `byteenable` out 4: lane enables.
- `writedata` out 32: lane-placed store data.
- `waitrequest` in 1: slave stall.
- `readdata` in 32: slave data, with the enabled lanes packed toward bit 0.

## Operation
- FSM states:
  - IDLE: `req_ready` = 1. On accept, latch op, addr, wdata and rd. Aligned requests go to BUS; misaligned requests go to RESP with the fault flag set.
  - BUS: `read` (loads) or `write` (stores) held high. When `waitrequest` = 0, capture `readdata` and go to RESP.
  - RESP: `rsp_valid` = 1 for one cycle, then return to IDLE.
- Misaligned conditions:
  - LH/LHU/SH with `req_addr[0]` = 1.
  - LW/SW with `req_addr[1:0]` ≠ 0.
  - A misaligned request produces no bus activity.
- Byte enables, with k = `req_addr[1:0]`:
  - Byte operations: `byteenable` = 1<<k.
  - Halfword operations: 0011 if `req_addr[1]` = 0, else 1100.
  - Word operations: 1111.
- Store data:
  - SB: the byte is replicated to all four lanes.
  - SH: the halfword is replicated to both halves.
  - SW: the data is passed unchanged.
- Load result, taken from the right-justified `readdata`:
  - LB: sign-extend [7:0].
  - LBU: zero-extend [7:0].
  - LH: sign-extend [15:0].
  - LHU: zero-extend [15:0].
  - LW: all 32 bits.
- `addr`, `byteenable` and `writedata` hold stable for the whole of BUS. In all other states `read`/`write` = 0 and the bus outputs are 0.

## Timing
- Reset (`reset_n` = 0 at a rising edge):
  - State returns to IDLE.
  - All outputs = 0, except `req_ready` = 1.
  - Any in-flight transaction is abandoned, with no response. Strobes drop at that same edge.
- The accept edge is cycle 0. `read`/`write` are registered and high in cycle 1.
- With no stall, the transaction completes in cycle 1 and `rsp_valid` is high in cycle 2.
- Each stall cycle (`waitrequest` = 1 while strobed) adds one cycle of latency.
- Misaligned requests: `rsp_valid` is high in cycle 1.
- `req_ready` falls in cycle 1 and rises in the cycle after the `rsp_valid` pulse. Throughput is at most one request every 3 cycles.
- `req_*` inputs are ignored when `req_ready` = 0.

## Structure
- Package `mips_cpu_bus_pkg` contains:
  - `lsu_op_t` enum: LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7.
  - An `lsu_state_t` enum.
  - Helper functions `is_store(op)` and `op_size(op)`.
- A natural sub-module is `mips_cpu_bus_lsu_align`. It is purely combinational and produces `byteenable`, the misalignment flag, the replicated store data and the extended load result.
- The FSM, registers and bus drive live in `mips_cpu_bus_lsu`.

## Test plan
All scenarios use `mips_cpu_bus_tb_memory` as the slave, plus a waitrequest-injecting wrapper for stall cases.
- **Word store:** SW 0xabcd12ff to 0x18, no stall.
  - Cycle 1: `write`=1, `addr`=0x18, `byteenable`=1111.
  - Cycle 2: `rsp_valid`=1, `rsp_data`=0.
- **Byte loads:**
  - LB 0x1b → `byteenable`=1000, `rsp_data`=0xffffffab.
  - LBU 0x1b → 0x000000ab.
  - LB 0x18 → 0xffffffff.
- **Halfword loads:**
  - LH 0x1a → `byteenable`=1100, 0xffffabcd.
  - LHU 0x18 → 0x000012ff.
- **Byte store then word load:**
  - SB 0x5a to 0x19 → `byteenable`=0010, `writedata`=0x5a5a5a5a.
  - LW 0x18 → 0xabcd5aff.
- **Stall:** `waitrequest` held high for 3 cycles on LW 0x18.
  - Bus outputs stay stable through the stall.
  - `rsp_valid` in cycle 5.
- **Faults and reset:**
  - LH 0x19 → no strobe; `rsp_valid` in cycle 1 with `rsp_misaligned`=1.
  - `reset_n`=0 mid-stall → `read`=0 at that edge, no `rsp_valid`, `req_ready`=1.
